// File: rtl/ddr_init_handshake.sv
// Per-channel LPDDR4 init-done collector answering a 4-phase req/ack handshake, with watchdog.
// Optional macro DDR_HS_REARM_EN: each new request clears ch_flag/initial_flag and re-evaluates init.
module ddr_init_handshake #(
  parameter int NUM_CH = 4,
  parameter int TO_W   = 16,
  parameter int TO_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_init_done,
  input  logic              req_i,
  output logic              ack_o,
  output logic [NUM_CH-1:0] ch_flag,
  output logic              initial_flag,
  output logic              timeout_o,
  output logic [1:0]        state_o,
  output logic [TO_W-1:0]   wait_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TO_CYC - 1);

  state_t            state_q;
  logic [NUM_CH-1:0] ch_flag_q;
  logic [NUM_CH-1:0] ch_flag_d;
  logic              init_q;
  logic              ack_q;
  logic              timeout_q;
  logic [TO_W-1:0]   cnt_q;
  logic [TO_W-1:0]   cnt_d;
  logic              all_done;
  logic              cnt_hit;

  // Disabled channels count as done, so an empty mask completes immediately.
  assign ch_flag_d = ch_flag_q | (ch_init_done & ch_en);
  assign all_done  = &(ch_flag_d | ~ch_en);
  assign cnt_hit   = (cnt_q == CNT_LAST);
  assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + TO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_flag_q <= '0;
      init_q    <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ch_flag_q <= ch_flag_d;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`ifdef DDR_HS_REARM_EN
            ch_flag_q <= '0;
            init_q    <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          // Completion has priority over a watchdog expiring in the same cycle.
          if (all_done) begin
            state_q <= S_ACK;
            init_q  <= 1'b1;
            ack_q   <= 1'b1;
          end else if (cnt_hit) begin
            state_q   <= S_ERR;
            timeout_q <= 1'b1;
            ack_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ACK, S_ERR: begin
          if (!req_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_o        = ack_q;
  assign ch_flag      = ch_flag_q;
  assign initial_flag = init_q;
  assign timeout_o    = timeout_q;
  assign state_o      = state_q;
  assign wait_cnt     = cnt_q;

endmodule

// File: doc/ddr_init_handshake.md
# ddr_init_handshake

Parametrised, multi-channel successor to the global DLA-to-memory handshake. Collects per-channel initialization-done indications from an NUM_CH-channel LPDDR4 controller and answers a 4-phase req/ack handshake from the DLA side. Acknowledgement is given once every enabled channel has reported done, or when a watchdog expires. Sits between the DLA request path and the memory controller channel wrappers in both RTL and the dla2mem verification environment.

## Interface
- NUM_CH, 4: number of controller channels, 1..16.
- TO_W, 16: width of the watchdog counter.
- TO_CYC, 1000: timeout in clk cycles spent in WAIT, 1..2^TO_W-1.

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  channel enable mask, sampled live every cycle.
- ch_init_done  in  NUM_CH  per-channel init-done level, synchronous to clk.
- req_i  in  1  4-phase request from DLA side.
- ack_o  out  1  4-phase acknowledge.
- ch_flag  out  NUM_CH  sticky per-channel done flags.
- initial_flag  out  1  sticky: all enabled channels done.
- timeout_o  out  1  watchdog expired on the last request.
- state_o  out  2  FSM state: 0 IDLE, 1 WAIT, 2 ACK, 3 ERR.
- wait_cnt  out  TO_W  cycles spent in the current WAIT.

## Operation
- Reset value of every output is 0, so the FSM starts in IDLE.
- done_nxt = ch_flag | (ch_init_done & ch_en). all_done = &(done_nxt | ~ch_en).
- ch_flag <= done_nxt in every state. Once set, a bit stays set until reset.
- IDLE
  - If req_i=1, go to WAIT.
  - On that transition, clear wait_cnt and timeout_o.
- WAIT
  - If all_done, go to ACK and set initial_flag.
  - Else, if wait_cnt == TO_CYC-1, go to ERR and set timeout_o.
  - Else, wait_cnt increments, saturating at all-ones.
  - If all_done and timeout occur in the same cycle, completion wins: go to ACK and leave timeout_o at 0.
- ACK: ack_o=1. When req_i=0, go to IDLE and drop ack_o.
- ERR
  - ack_o=1 and timeout_o=1.
  - When req_i=0, go to IDLE. ack_o drops; timeout_o holds until the next request.
- req_i falling while in WAIT is a protocol violation. The FSM stays in WAIT, and the request completes and acks normally.
- ch_en=0 is treated as vacuously complete: WAIT lasts exactly one cycle, then ACK.
- A channel disabled mid-WAIT stops gating completion immediately. Its ch_flag bit keeps its value.
- Reset mid-operation clears everything asynchronously. The requester must restart the handshake.

## Timing
- req_i high at edge k (IDLE): state_o=WAIT after k.
- If all_done at edge k+1, ack_o=1 and initial_flag=1 after k+1.
- Minimum latency is therefore 2 cycles from req_i sampled to ack_o.
- Timeout: with no completion, ack_o and timeout_o rise after the edge where wait_cnt == TO_CYC-1, which is TO_CYC cycles after entering WAIT.
- ack_o falls 1 cycle after req_i is sampled low.
- A new req_i is accepted no earlier than the cycle after returning to IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- DDR_HS_REARM_EN defined:
  - The IDLE to WAIT transition also clears ch_flag and initial_flag.
  - Each request therefore re-evaluates init, for example after self-refresh exit or a channel re-train.
- DDR_HS_REARM_EN undefined:
  - ch_flag and initial_flag are sticky from reset onward.
  - Once initial_flag=1, each request acks in the minimum 2 cycles regardless of ch_init_done.

## Test plan
- Basic completion:
  - Stimulus: NUM_CH=4, ch_en=4'hF; ch_init_done bits rise at cycles 5, 9, 12, 20; req_i rises at cycle 2.
  - Required: ch_flag tracks each bit; ack_o=1 and initial_flag=1 one cycle after cycle 20; ack_o drops 1 cycle after req_i falls.
- Timeout:
  - Stimulus: TO_CYC=16; ch_init_done=4'h7 (channel 3 stuck); req_i high.
  - Required: ack_o=1, timeout_o=1 and state_o=3 exactly 16 cycles after entering WAIT.
  - Required: after req_i falls, state_o=0 and timeout_o stays 1 until the next req_i.
- Masking and simultaneity:
  - Stimulus: ch_en=4'h7 with channel 3 never done.
  - Required: ACK with timeout_o=0.
  - Stimulus: the final done bit arrives in the cycle where wait_cnt == TO_CYC-1.
  - Required: ACK, with timeout_o=0.
- Empty mask: ch_en=0, req_i high -> WAIT for 1 cycle, ack_o after 2 cycles, initial_flag=1.
- Reset mid-WAIT:
  - Stimulus: assert rst_n=0 asynchronously.
  - Required: all outputs 0 immediately, without waiting for a clock edge; a restarted handshake completes normally.
- Rearm:
  - Stimulus: complete one handshake, drop all ch_init_done, issue a second request.
  - Required with DDR_HS_REARM_EN: flags clear and the second request times out.
  - Required without it: ack_o after 2 cycles, with initial_flag still 1.
